// File: rtl/wb_line_loader.sv
// Packs a 32-bit valid/ready weight stream into 416-bit buffer lines and
// writes each line to the weight buffer BRAM controller port with byte enables.
module wb_line_loader #(
  parameter int DATA_W         = 32,
  parameter int WORDS_PER_LINE = 13,
  parameter int ADDR_W         = 13,
  localparam int LINE_W        = DATA_W * WORDS_PER_LINE,
  localparam int BE_W          = LINE_W / 8,
  localparam int WBE_W         = DATA_W / 8,
  localparam int CNT_W         = $clog2(WORDS_PER_LINE)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_start_addr,
  input  logic [DATA_W-1:0] i_s_data,
  input  logic              i_s_valid,
  input  logic              i_s_last,
  output logic              o_s_ready,
  output logic [LINE_W-1:0] o_wb_bramctl_wdata,
  output logic [ADDR_W-1:0] o_wb_bramctl_addr,
  output logic [BE_W-1:0]   o_wb_bramctl_be,
  output logic              o_wb_bramctl_we,
  output logic              o_wb_bramctl_en,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W:0]   o_lines_written,
  output logic              o_wrap
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t              r_state, w_next;
  logic [CNT_W-1:0]    r_k;
  logic [LINE_W-1:0]   r_line, r_wdata, w_line;
  logic [BE_W-1:0]     r_be, r_wbe, w_be;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_lines;
  logic                r_we, r_busy, r_done, r_wrap;
  logic                w_hs, w_close;

  assign w_hs    = (r_state == S_LOAD) && i_s_valid;
  assign w_close = w_hs && ((r_k == CNT_W'(WORDS_PER_LINE - 1)) || i_s_last);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_LOAD;
      S_LOAD:  if (w_hs && i_s_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Current line with the incoming word merged in; becomes the write image on close.
  always_comb begin
    w_line = r_line;
    w_be   = r_be;
    w_line[r_k * DATA_W +: DATA_W] = i_s_data;
    w_be[r_k * WBE_W +: WBE_W]     = '1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_k     <= '0;
      r_line  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_wbe   <= '0;
      r_addr  <= '0;
      r_lines <= '0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= (r_state == S_DONE);
      if (r_state == S_IDLE && i_start) begin
        r_addr  <= i_start_addr;
        r_k     <= '0;
        r_line  <= '0;
        r_be    <= '0;
        r_lines <= '0;
        r_wrap  <= 1'b0;
        r_busy  <= 1'b1;
      end
      if (r_state == S_DONE) r_busy <= 1'b0;
      // Address advances after the write cycle, so a line closing during the
      // write cycle picks up the incremented address on its own write.
      if (r_we) begin
        r_addr <= r_addr + 1'b1;
        if (r_addr == '1) r_wrap <= 1'b1;
        if (r_lines != '1) r_lines <= r_lines + 1'b1;
      end
      if (w_hs) begin
        if (w_close) begin
          r_wdata <= w_line;
          r_wbe   <= w_be;
          r_we    <= 1'b1;
          r_k     <= '0;
          r_line  <= '0;
          r_be    <= '0;
        end else begin
          r_k     <= r_k + 1'b1;
          r_line  <= w_line;
          r_be    <= w_be;
        end
      end
    end
  end

  assign o_s_ready          = (r_state == S_LOAD);
  assign o_wb_bramctl_wdata = r_wdata;
  assign o_wb_bramctl_addr  = r_addr;
  assign o_wb_bramctl_be    = r_wbe;
  assign o_wb_bramctl_we    = r_we;
  assign o_wb_bramctl_en    = r_we;
  assign o_busy             = r_busy;
  assign o_done             = r_done;
  assign o_lines_written    = r_lines;
  assign o_wrap             = r_wrap;

endmodule

// File: tb/tb_wb_line_loader.sv
// Scoreboard bench for wb_line_loader: expected line writes are queued as
// words are accepted and compared when the BRAM port write appears.
module tb_wb_line_loader;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [12:0]   i_start_addr = '0;
  logic [31:0]   i_s_data = '0;
  logic          i_s_valid = 1'b0;
  logic          i_s_last = 1'b0;
  logic          o_s_ready;
  logic [415:0]  o_wb_bramctl_wdata;
  logic [12:0]   o_wb_bramctl_addr;
  logic [51:0]   o_wb_bramctl_be;
  logic          o_wb_bramctl_we;
  logic          o_wb_bramctl_en;
  logic          o_busy;
  logic          o_done;
  logic [13:0]   o_lines_written;
  logic          o_wrap;

  wb_line_loader dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_start_addr(i_start_addr),
    .i_s_data(i_s_data), .i_s_valid(i_s_valid), .i_s_last(i_s_last), .o_s_ready(o_s_ready),
    .o_wb_bramctl_wdata(o_wb_bramctl_wdata), .o_wb_bramctl_addr(o_wb_bramctl_addr),
    .o_wb_bramctl_be(o_wb_bramctl_be), .o_wb_bramctl_we(o_wb_bramctl_we),
    .o_wb_bramctl_en(o_wb_bramctl_en), .o_busy(o_busy), .o_done(o_done),
    .o_lines_written(o_lines_written), .o_wrap(o_wrap)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [12:0]  a;
    logic [51:0]  be;
    logic [415:0] d;
  } wr_t;

  wr_t          sb[$];
  int           n_pass = 0, n_total = 0;
  int           wr_cnt = 0, stalls = 0;
  logic [415:0] last_d;
  logic [51:0]  last_be;
  logic [12:0]  last_a;

  // Reference packer state
  logic [415:0] m_line;
  logic [51:0]  m_be;
  int           m_k;
  logic [12:0]  m_addr;

  always @(negedge i_clk) begin
    if (o_wb_bramctl_we || o_wb_bramctl_en) begin
      wr_t e;
      wr_cnt++;
      last_d  = o_wb_bramctl_wdata;
      last_be = o_wb_bramctl_be;
      last_a  = o_wb_bramctl_addr;
      n_total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_write: got addr %0h, required no write", o_wb_bramctl_addr);
      end else begin
        e = sb.pop_front();
        if (o_wb_bramctl_addr !== e.a || o_wb_bramctl_be !== e.be || o_wb_bramctl_wdata !== e.d
            || o_wb_bramctl_en !== o_wb_bramctl_we)
          $display("FAIL write: got addr %0h be %0h en %b we %b, required addr %0h be %0h en=we",
                   o_wb_bramctl_addr, o_wb_bramctl_be, o_wb_bramctl_en, o_wb_bramctl_we, e.a, e.be);
        else n_pass++;
      end
    end
  end

  task automatic model_start(input logic [12:0] a);
    m_line = '0; m_be = '0; m_k = 0; m_addr = a;
  endtask

  task automatic do_start(input logic [12:0] a);
    i_start = 1'b1; i_start_addr = a;
    @(posedge i_clk); #1;
    i_start = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input bit l);
    int n = 0;
    i_s_data = d; i_s_last = l; i_s_valid = 1'b1;
    @(negedge i_clk);
    while (!o_s_ready && n < 20) begin @(negedge i_clk); n++; end
    stalls += n;
    if (!o_s_ready) begin
      n_total++;
      $display("FAIL send_timeout: got ready 0, required ready 1 within 20 cycles");
    end else begin
      m_line[m_k*32 +: 32] = d;
      m_be[m_k*4 +: 4] = 4'hF;
      m_k++;
      if (m_k == 13 || l) begin
        sb.push_back('{a: m_addr, be: m_be, d: m_line});
        m_addr = m_addr + 13'd1;
        m_line = '0; m_be = '0; m_k = 0;
      end
    end
    @(posedge i_clk); #1;
    i_s_valid = 1'b0; i_s_last = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int exp_lines, input bit exp_wrap);
    int n = 0;
    @(negedge i_clk);
    while (!o_done && n < 60) begin @(negedge i_clk); n++; end
    n_total++;
    if (o_done !== 1'b1 || o_busy !== 1'b0)
      $display("FAIL %s_done: got done %b busy %b, required done 1 busy 0", nm, o_done, o_busy);
    else n_pass++;
    n_total++;
    if (o_lines_written !== 14'(exp_lines) || o_wrap !== exp_wrap)
      $display("FAIL %s_count: got lines %0d wrap %b, required lines %0d wrap %b",
               nm, o_lines_written, o_wrap, exp_lines, exp_wrap);
    else n_pass++;
    n_total++;
    if (sb.size() != 0)
      $display("FAIL %s_pending: got %0d writes missing, required 0", nm, sb.size());
    else n_pass++;
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge i_clk);
    n_total++;
    if (o_s_ready !== 0 || o_wb_bramctl_we !== 0 || o_wb_bramctl_en !== 0 || o_busy !== 0 ||
        o_done !== 0 || o_lines_written !== 0 || o_wrap !== 0 || o_wb_bramctl_addr !== 0 ||
        o_wb_bramctl_be !== 0 || o_wb_bramctl_wdata !== 0)
      $display("FAIL reset_outputs: got ready %b we %b busy %b lines %0d addr %0h, required all 0",
               o_s_ready, o_wb_bramctl_we, o_busy, o_lines_written, o_wb_bramctl_addr);
    else n_pass++;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
  endtask

  task automatic test_full_line();
    do_start(13'h010); model_start(13'h010);
    n_total++;
    if (o_busy !== 1'b1) $display("FAIL full_busy: got %b, required 1", o_busy);
    else n_pass++;
    for (int i = 1; i <= 13; i++) send(32'(i), i == 13);
    @(negedge i_clk);
    n_total++;
    if (o_done !== 1'b0 || o_busy !== 1'b1)
      $display("FAIL full_done_early: got done %b busy %b, required done 0 busy 1", o_done, o_busy);
    else n_pass++;
    @(negedge i_clk);
    n_total++;
    if (o_done !== 1'b1 || o_busy !== 1'b0 || o_lines_written !== 14'd1)
      $display("FAIL full_done_timing: got done %b busy %b lines %0d, required 1 0 1",
               o_done, o_busy, o_lines_written);
    else n_pass++;
    n_total++;
    if (last_a !== 13'h010 || last_be !== 52'hF_FFFF_FFFF_FFFF || last_d[31:0] !== 32'd1 ||
        last_d[415:384] !== 32'hD)
      $display("FAIL full_line: got addr %0h be %0h w0 %0h w12 %0h, required 10 fffffffffffff 1 d",
               last_a, last_be, last_d[31:0], last_d[415:384]);
    else n_pass++;
    n_total++;
    if (wr_cnt !== 1) $display("FAIL full_writes: got %0d, required 1", wr_cnt);
    else n_pass++;
    @(posedge i_clk); #1;
  endtask

  task automatic test_partial();
    int w0 = wr_cnt;
    do_start(13'h033); model_start(13'h033);
    for (int i = 0; i < 5; i++) send(32'hA500_0000 + 32'(i), i == 4);
    wait_done("partial", 1, 0);
    n_total++;
    if (last_be !== 52'h0_0000_000F_FFFF || last_d[415:160] !== '0 || wr_cnt - w0 != 1)
      $display("FAIL partial_line: got be %0h writes %0d, required be fffff, upper data 0, 1 write",
               last_be, wr_cnt - w0);
    else n_pass++;
  endtask

  task automatic test_wrap();
    do_start(13'h1FFF); model_start(13'h1FFF);
    for (int i = 0; i < 26; i++) send($urandom, i == 25);
    wait_done("wrap", 2, 1);
    n_total++;
    if (last_a !== 13'h0000) $display("FAIL wrap_addr: got %0h, required 0", last_a);
    else n_pass++;
  endtask

  task automatic test_gapped();
    int w0 = wr_cnt;
    stalls = 0;
    do_start(13'h0A0); model_start(13'h0A0);
    for (int i = 0; i < 39; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge i_clk);
        n_total++;
        if (o_s_ready !== 1'b1) $display("FAIL gap_ready: got %b, required 1", o_s_ready);
        else n_pass++;
        @(posedge i_clk); #1;
      end
      send($urandom, i == 38);
    end
    wait_done("gapped", 3, 0);
    n_total++;
    if (wr_cnt - w0 != 3 || stalls != 0)
      $display("FAIL gapped_writes: got %0d writes %0d stalls, required 3 writes 0 stalls",
               wr_cnt - w0, stalls);
    else n_pass++;
  endtask

  task automatic test_start_busy();
    do_start(13'h040); model_start(13'h040);
    for (int i = 0; i < 5; i++) send(32'h100 + 32'(i), 1'b0);
    do_start(13'h100);
    n_total++;
    if (o_busy !== 1'b1 || o_s_ready !== 1'b1)
      $display("FAIL busy_start: got busy %b ready %b, required 1 1", o_busy, o_s_ready);
    else n_pass++;
    for (int i = 5; i < 26; i++) send(32'h100 + 32'(i), i == 25);
    wait_done("start_busy", 2, 0);
    n_total++;
    if (last_a !== 13'h041) $display("FAIL busy_addr: got %0h, required 41", last_a);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int w0 = wr_cnt;
    do_start(13'h0300); model_start(13'h0300);
    for (int i = 0; i < 7; i++) send(32'hC0 + 32'(i), 1'b0);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    n_total++;
    if (o_s_ready !== 0 || o_busy !== 0 || o_wb_bramctl_we !== 0 || o_lines_written !== 0 ||
        o_wb_bramctl_addr !== 0 || o_wb_bramctl_be !== 0 || o_done !== 0 || o_wrap !== 0)
      $display("FAIL rst_mid_outputs: got ready %b busy %b we %b addr %0h, required all 0",
               o_s_ready, o_busy, o_wb_bramctl_we, o_wb_bramctl_addr);
    else n_pass++;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    n_total++;
    if (wr_cnt != w0) $display("FAIL rst_mid_write: got %0d writes, required 0", wr_cnt - w0);
    else n_pass++;
    do_start(13'h020); model_start(13'h020);
    for (int i = 0; i < 13; i++) send(32'hD0 + 32'(i), i == 12);
    wait_done("rst_mid", 1, 0);
    n_total++;
    if (last_a !== 13'h020) $display("FAIL rst_mid_addr: got %0h, required 20", last_a);
    else n_pass++;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_line();
    test_partial();
    test_wrap();
    test_gapped();
    test_start_busy();
    test_reset_mid();
    repeat (3) @(posedge i_clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
